// File: rtl/fifo_param_c.sv
// Synchronous FIFO with registered read port, occupancy counter and hysteretic almost_full flag.
// Optional macro FIFO_PARAM_STICKY_ERR_EN makes error sticky until reset; otherwise it is a one-cycle pulse.
module fifo_param_c #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] data_in,
  input  logic          push,
  input  logic          pop,
  input  logic [AW:0]   umbral_almost_full,
  input  logic [AW:0]   umbral_almost_empty,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic          almost_full,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic [AW:0]   count,
  output logic          error
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic [DW-1:0] data_out_reg;
  logic          valid_reg, almost_full_reg, almost_full_next;
  logic          error_reg, error_next;
  logic          pop_ok, push_ok, offending;

  // A push into a full FIFO is still legal when a pop frees a slot in the same cycle.
  always_comb begin
    pop_ok    = pop && (count_reg != '0);
    push_ok   = push && ((count_reg != FULL_CNT) || pop_ok);
    offending = (pop && !pop_ok) || (push && !push_ok);

    count_next = count_reg;
    if (push_ok && !pop_ok)
      count_next = count_reg + 1'b1;
    else if (pop_ok && !push_ok)
      count_next = count_reg - 1'b1;

    // Set wins over clear so misprogrammed thresholds resolve toward back-pressure.
    almost_full_next = almost_full_reg;
    if (count_next >= umbral_almost_full)
      almost_full_next = 1'b1;
    else if (count_next <= umbral_almost_empty)
      almost_full_next = 1'b0;

`ifdef FIFO_PARAM_STICKY_ERR_EN
    error_next = error_reg || offending;
`else
    error_next = offending;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset && push_ok)
      mem[wr_ptr_reg] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      data_out_reg    <= '0;
      valid_reg       <= 1'b0;
      almost_full_reg <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      valid_reg <= pop_ok;
      if (pop_ok) begin
        data_out_reg <= mem[rd_ptr_reg];
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
      end
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      count_reg       <= count_next;
      almost_full_reg <= almost_full_next;
      error_reg       <= error_next;
    end
  end

  assign data_out    = data_out_reg;
  assign valid_out   = valid_reg;
  assign almost_full = almost_full_reg;
  assign error       = error_reg;
  assign count       = count_reg;
  assign fifo_empty  = (count_reg == '0);
  assign fifo_full   = (count_reg == FULL_CNT);

endmodule

// File: tb/tb_fifo_param_c.sv
// Randomized self-checking bench for fifo_param_c against a queue-based reference model.
module tb_fifo_param_c;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [3:0] umbral_almost_full = 4'd6;
  logic [3:0] umbral_almost_empty = 4'd2;
  logic [7:0] data_out;
  logic       valid_out, almost_full, fifo_empty, fifo_full, error;
  logic [3:0] count;

  fifo_param_c #(.DW(8), .AW(3)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .push(push), .pop(pop),
    .umbral_almost_full(umbral_almost_full), .umbral_almost_empty(umbral_almost_empty),
    .data_out(data_out), .valid_out(valid_out), .almost_full(almost_full),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .count(count), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_dout  = '0;
  logic       exp_valid = 1'b0;
  logic       exp_af    = 1'b0;
  logic       exp_err   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model by the FIFO's rules, then compare every output.
  task automatic cycle(input logic rst_n, input logic p, input logic q, input logic [7:0] d);
    int  cnt;
    bit  pop_acc, push_acc, bad;
    reset = rst_n; push = p; pop = q; data_in = d;
    @(posedge clk);
    if (!rst_n) begin
      model_q.delete();
      exp_dout = '0; exp_valid = 0; exp_af = 0; exp_err = 0;
    end else begin
      cnt      = model_q.size();
      pop_acc  = q && cnt > 0;
      push_acc = p && (cnt < 8 || pop_acc);
      bad      = (q && !pop_acc) || (p && !push_acc);
      exp_valid = pop_acc;
      if (pop_acc) exp_dout = model_q.pop_front();
      if (push_acc) model_q.push_back(d);
      if (model_q.size() >= int'(umbral_almost_full)) exp_af = 1;
      else if (model_q.size() <= int'(umbral_almost_empty)) exp_af = 0;
`ifdef FIFO_PARAM_STICKY_ERR_EN
      exp_err = exp_err | bad;
`else
      exp_err = bad;
`endif
    end
    #1;
    check_val("count", 32'(count), 32'(model_q.size()));
    check_val("fifo_empty", 32'(fifo_empty), 32'(model_q.size() == 0));
    check_val("fifo_full", 32'(fifo_full), 32'(model_q.size() == 8));
    check_val("valid_out", 32'(valid_out), 32'(exp_valid));
    check_val("data_out", 32'(data_out), 32'(exp_dout));
    check_val("almost_full", 32'(almost_full), 32'(exp_af));
    check_val("error", 32'(error), 32'(exp_err));
    $display("cyc rst_n=%0b push=%0b pop=%0b din=%02h -> count=%0d dout=%02h v=%0b af=%0b err=%0b",
             rst_n, p, q, d, count, data_out, valid_out, almost_full, error);
  endtask

  initial begin
    // Reset state
    cycle(0, 0, 0, 8'h00);
    cycle(0, 1, 1, 8'h55);
    // Pop on empty after reset
    cycle(1, 0, 1, 8'h00);
    cycle(1, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    // Fill with 0x11..0x18
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 8'(8'h11 + i));
    // Overflow attempt while full, then clear via reset and refill
    cycle(1, 1, 0, 8'hEE);
    cycle(0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 8'(8'h11 + i));
    // Push and pop together while full
    cycle(1, 1, 1, 8'hAA);
    // Drain completely
    for (int i = 0; i < 8; i++) cycle(1, 0, 1, 8'h00);
    cycle(1, 0, 0, 8'h00);
    // Simultaneous push/pop on empty: push only
    cycle(1, 1, 1, 8'h3C);
    cycle(0, 0, 0, 8'h00);
    // Interleaved traffic across pointer wrap
    for (int i = 0; i < 20; i++)
      cycle(1, (i % 3) != 2, (i % 2) == 1, 8'(8'h40 + i));
    // Reset asserted with count=5 and a push pending
    cycle(0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 8'(8'h80 + i));
    cycle(0, 1, 0, 8'hFF);
    // Random traffic with default thresholds
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
            $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 8'($urandom));
    // Random traffic with random, possibly misprogrammed thresholds
    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0) begin
        umbral_almost_full  = 4'($urandom_range(0, 8));
        umbral_almost_empty = 4'($urandom_range(0, 8));
      end
      cycle(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
            $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 50, 8'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_param_c.md
FIFO_PARAM_C -- requirements
Module: fifo_param_c

Interface
REQ-001 SHALL have parameter: DW, 8, data width in bits (>=1).
REQ-002 SHALL have parameter: AW, 3, address width; depth = 2**AW entries (AW>=1).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port: reset  input  1  synchronous, active-low reset; sampled on posedge clk only.
REQ-005 SHALL have port: data_in  input  DW  write data, sampled when push=1.
REQ-006 SHALL have port: push  input  1  write request.
REQ-007 SHALL have port: pop  input  1  read request.
REQ-008 SHALL have port: umbral_almost_full  input  AW+1  occupancy at or above which almost_full asserts.
REQ-009 SHALL have port: umbral_almost_empty  input  AW+1  occupancy at or below which almost_full deasserts.
REQ-010 SHALL have port: data_out  output  DW  registered read data.
REQ-011 SHALL have port: valid_out  output  1  data_out valid, one-cycle pulse per accepted pop.
REQ-012 SHALL have port: almost_full  output  1  flow-control flag, with hysteresis.
REQ-013 SHALL have port: fifo_empty  output  1  occupancy == 0.
REQ-014 SHALL have port: fifo_full  output  1  occupancy == 2**AW.
REQ-015 SHALL have port: count  output  AW+1  current occupancy, 0..2**AW.
REQ-016 SHALL have port: error  output  1  overflow/underflow indication.

Function
REQ-017 SHALL store entries in an internal 2**AW x DW array addressed by wr_ptr/rd_ptr (AW bits each), both wrapping modulo 2**AW.
REQ-018 SHALL accept a push when not full, or when full and pop is accepted in the same cycle; write at wr_ptr, wr_ptr+1.
REQ-019 SHALL accept a pop only when count>0; data_out <= mem[rd_ptr] (pre-write value), rd_ptr+1, valid_out=1 on the next cycle (latency 1).
REQ-020 SHALL, on pop with count==0, leave data_out unchanged, keep valid_out=0, and raise error; pop is discarded.
REQ-021 SHALL, on push while full without an accepted pop, discard data_in, leave pointers unchanged, and raise error.
REQ-022 SHALL, on simultaneous push and pop while empty, accept the push only (no bypass) and raise error for the pop; count becomes 1.
REQ-023 SHALL update count: +1 on accepted push alone, -1 on accepted pop alone, unchanged on both or neither.
REQ-024 SHALL drive fifo_empty, fifo_full, count combinationally from the registered occupancy.
REQ-025 SHALL register almost_full: set when next count >= umbral_almost_full; clear when next count <= umbral_almost_empty; otherwise hold.
REQ-026 SHALL treat set as having priority when both threshold conditions are true (misprogrammed thresholds).
REQ-027 SHALL never assert almost_full when umbral_almost_full == 0 is not reached by design; umbral_almost_full = 0 forces almost_full=1 after the first clock out of reset.

Reset
REQ-028 SHALL, when reset==0 at posedge clk, clear wr_ptr, rd_ptr, count, data_out, valid_out, almost_full, error; memory contents are not cleared.
REQ-029 SHALL, after reset, present fifo_empty=1, fifo_full=0, count=0.
REQ-030 SHALL let reset override any push/pop in the same cycle; in-flight data is discarded.

Configuration
REQ-031 SHALL support macro FIFO_PARAM_STICKY_ERR_EN.
REQ-032 SHALL, with FIFO_PARAM_STICKY_ERR_EN defined, hold error=1 from the offending cycle until reset.
REQ-033 SHALL, without FIFO_PARAM_STICKY_ERR_EN, pulse error=1 for exactly one cycle after each offending request.

Verification (DW=8, AW=3, umbral_almost_full=6, umbral_almost_empty=2)
REQ-034 SHALL verify: reset=0 then push 0x11..0x18 (8 cycles) -> count=8, fifo_full=1, almost_full=1 from 6th push, error=0.
REQ-035 SHALL verify: from full, 8 pops -> data_out 0x11..0x18 in order, each valid_out one cycle after pop; almost_full clears when count reaches 2; fifo_empty=1 at end.
REQ-036 SHALL verify: pop on empty after reset -> valid_out=0, error=1 (sticky with macro, one-cycle pulse without).
REQ-037 SHALL verify: full FIFO, push 0xAA with pop -> data_out=0x11, count stays 8, no error; later read order ends with 0xAA.
REQ-038 SHALL verify: 20 push/pop interleaved cycles crossing pointer wrap -> data order preserved, count correct each cycle.
REQ-039 SHALL verify: reset=0 asserted with count=5 and push=1 -> next cycle count=0, valid_out=0, almost_full=0, error=0.
